// File: rtl/asap_control.sv
// Fetch/execute sequencer for the ASAP-1 datapath: decodes the IR opcode into
// per-cycle bus strobes and keeps the zero/carry flags used by JZ/JC.
module asap_control (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zf,
  input  logic       cf,
  output logic       pc_oe,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_oe,
  output logic       ram_load,
  output logic       ir_load,
  output logic       ir_oe,
  output logic       a_load,
  output logic       a_oe,
  output logic       b_load,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] step
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_ILL  = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  state_t r_state;
  state_t w_next;
  state_t w_after;
  logic   r_zflag;
  logic   r_cflag;
  logic   w_alu_op;
  logic   w_flag_ld;

  // Where the sequencer goes once the current instruction's last step ends.
  assign w_after   = run ? S_T0 : S_IDLE;
  assign w_alu_op  = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign w_flag_ld = (r_state == S_T4) && w_alu_op;
  assign step      = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Flags latch on the same edge that writes the ALU result into A.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_zflag <= 1'b0;
      r_cflag <= 1'b0;
    end else if (w_flag_ld) begin
      r_zflag <= zf;
      r_cflag <= cf;
    end
  end

  always_comb begin
    w_next   = r_state;
    pc_oe    = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mar_load = 1'b0;
    ram_oe   = 1'b0;
    ram_load = 1'b0;
    ir_load  = 1'b0;
    ir_oe    = 1'b0;
    a_load   = 1'b0;
    a_oe     = 1'b0;
    b_load   = 1'b0;
    alu_oe   = 1'b0;
    alu_sub  = 1'b0;
    out_load = 1'b0;
    halted   = 1'b0;

    case (r_state)
      S_IDLE: w_next = run ? S_T0 : S_IDLE;
      S_T0: begin
        pc_oe    = 1'b1;
        mar_load = 1'b1;
        w_next   = S_T1;
      end
      S_T1: begin
        ram_oe  = 1'b1;
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        w_next  = S_T2;
      end
      S_T2: begin
        w_next = w_after;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ir_oe    = 1'b1;
            mar_load = 1'b1;
            w_next   = S_T3;
          end
          OP_LDI: begin
            ir_oe  = 1'b1;
            a_load = 1'b1;
          end
          OP_JMP: begin
            ir_oe   = 1'b1;
            pc_load = 1'b1;
          end
          OP_JC: begin
            ir_oe   = 1'b1;
            pc_load = r_cflag;
          end
          OP_JZ: begin
            ir_oe   = 1'b1;
            pc_load = r_zflag;
          end
          OP_OUT: begin
            a_oe     = 1'b1;
            out_load = 1'b1;
          end
          OP_HLT:  w_next = S_HALT;
          OP_NOP:  w_next = w_after;
          default: w_next = w_after;
        endcase
      end
      S_T3: begin
        w_next = w_after;
        case (opcode)
          OP_LDA: begin
            ram_oe = 1'b1;
            a_load = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ram_oe = 1'b1;
            b_load = 1'b1;
            w_next = S_T4;
          end
          OP_STA: begin
            a_oe     = 1'b1;
            ram_load = 1'b1;
          end
          default: w_next = w_after;
        endcase
      end
      S_T4: begin
        w_next  = w_after;
        alu_oe  = w_alu_op;
        a_load  = w_alu_op;
        alu_sub = (opcode == OP_SUB);
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      S_ILL:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_asap_control.sv
// Bench for asap_control: an instruction-level model predicts step and strobes
// every cycle, with directed scenarios and literal checks around it.
module tb_asap_control;

  logic       clk = 1'b0;
  logic       rst, run, zf, cf;
  logic [3:0] opcode;
  logic pc_oe, pc_inc, pc_load, mar_load, ram_oe, ram_load, ir_load, ir_oe;
  logic a_load, a_oe, b_load, alu_oe, alu_sub, out_load, halted;
  logic [2:0] step;

  int n_vec = 0;
  int n_err = 0;

  asap_control dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zf(zf), .cf(cf),
    .pc_oe(pc_oe), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ram_oe(ram_oe), .ram_load(ram_load), .ir_load(ir_load), .ir_oe(ir_oe),
    .a_load(a_load), .a_oe(a_oe), .b_load(b_load), .alu_oe(alu_oe),
    .alu_sub(alu_sub), .out_load(out_load), .halted(halted), .step(step)
  );

  always #5 clk = ~clk;

  localparam logic [14:0] M_PC_OE    = 15'd1 << 14;
  localparam logic [14:0] M_PC_INC   = 15'd1 << 13;
  localparam logic [14:0] M_PC_LOAD  = 15'd1 << 12;
  localparam logic [14:0] M_MAR_LOAD = 15'd1 << 11;
  localparam logic [14:0] M_RAM_OE   = 15'd1 << 10;
  localparam logic [14:0] M_RAM_LOAD = 15'd1 << 9;
  localparam logic [14:0] M_IR_LOAD  = 15'd1 << 8;
  localparam logic [14:0] M_IR_OE    = 15'd1 << 7;
  localparam logic [14:0] M_A_LOAD   = 15'd1 << 6;
  localparam logic [14:0] M_A_OE     = 15'd1 << 5;
  localparam logic [14:0] M_B_LOAD   = 15'd1 << 4;
  localparam logic [14:0] M_ALU_OE   = 15'd1 << 3;
  localparam logic [14:0] M_ALU_SUB  = 15'd1 << 2;
  localparam logic [14:0] M_OUT_LOAD = 15'd1 << 1;
  localparam logic [14:0] M_HALTED   = 15'd1;

  function automatic logic [14:0] dut_strobes();
    return {pc_oe, pc_inc, pc_load, mar_load, ram_oe, ram_load, ir_load, ir_oe,
            a_load, a_oe, b_load, alu_oe, alu_sub, out_load, halted};
  endfunction

  function automatic int instr_len(logic [3:0] op);
    case (op)
      4'd1, 4'd4: return 4;
      4'd2, 4'd3: return 5;
      default:    return 3;
    endcase
  endfunction

  // Microstep table: mode 0 idle, 1 executing (k = cycle within instruction), 2 halted.
  function automatic logic [14:0] exp_strobes(int mode, int k, logic [3:0] op,
                                              logic z, logic c);
    logic [14:0] s;
    s = '0;
    if (mode == 2) s = M_HALTED;
    else if (mode == 1) begin
      if (k == 0) s = M_PC_OE | M_MAR_LOAD;
      else if (k == 1) s = M_RAM_OE | M_IR_LOAD | M_PC_INC;
      else if (k == 2) begin
        case (op)
          4'd1, 4'd2, 4'd3, 4'd4: s = M_IR_OE | M_MAR_LOAD;
          4'd5:  s = M_IR_OE | M_A_LOAD;
          4'd6:  s = M_IR_OE | M_PC_LOAD;
          4'd7:  s = M_IR_OE | (c ? M_PC_LOAD : 15'd0);
          4'd8:  s = M_IR_OE | (z ? M_PC_LOAD : 15'd0);
          4'd14: s = M_A_OE | M_OUT_LOAD;
          default: s = '0;
        endcase
      end else if (k == 3) begin
        if (op == 4'd1) s = M_RAM_OE | M_A_LOAD;
        else if (op == 4'd4) s = M_A_OE | M_RAM_LOAD;
        else s = M_RAM_OE | M_B_LOAD;
      end else begin
        s = M_ALU_OE | M_A_LOAD | ((op == 4'd3) ? M_ALU_SUB : 15'd0);
      end
    end
    return s;
  endfunction

  int   m_mode = 0;
  int   m_k = 0;
  logic m_z = 1'b0;
  logic m_c = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_k = 0; m_z = 1'b0; m_c = 1'b0;
    end else if (m_mode == 0) begin
      if (run) begin m_mode = 1; m_k = 0; end
    end else if (m_mode == 1) begin
      if (m_k == 4) begin m_z = zf; m_c = cf; end
      if (m_k == instr_len(opcode) - 1) begin
        if (opcode == 4'd15) m_mode = 2;
        else if (run) m_k = 0;
        else m_mode = 0;
      end else begin
        m_k = m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [14:0] es;
    logic [2:0]  est;
    es  = exp_strobes(m_mode, m_k, opcode, m_z, m_c);
    est = (m_mode == 0) ? 3'd0 : (m_mode == 2) ? 3'd7 : 3'(m_k + 1);
    n_vec++;
    if (dut_strobes() !== es) begin
      n_err++;
      $display("FAIL model_strobes t=%0t got %b want %b", $time, dut_strobes(), es);
    end
    n_vec++;
    if (step !== est) begin
      n_err++;
      $display("FAIL model_step t=%0t got %0d want %0d", $time, step, est);
    end
    n_vec++;
    assert ($onehot0({pc_oe, ram_oe, ir_oe, a_oe, alu_oe})) else begin
      n_err++;
      $display("FAIL bus_exclusive t=%0t drivers %b", $time, {pc_oe, ram_oe, ir_oe, a_oe, alu_oe});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_instr(input logic [3:0] op, input logic z, input logic c);
    opcode = op; zf = z; cf = c;
    adv(instr_len(op));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst = 1'b0; run = 1'b0; opcode = 4'd0; zf = 1'b0; cf = 1'b0;
    adv(2);
    chk("reset_step", 32'(step), 32'd0);
    chk("reset_strobes", 32'(dut_strobes()), 32'd0);

    // NOP stream: 1,2,3,1
    rst = 1'b1; run = 1'b1;
    adv(1); chk("nop_s1", 32'(step), 32'd1);
    chk("nop_t0", 32'({pc_oe, mar_load}), 32'd3);
    adv(1); chk("nop_s2", 32'(step), 32'd2);
    adv(1); chk("nop_s3", 32'(step), 32'd3);
    chk("nop_t2_quiet", 32'(dut_strobes()), 32'd0);
    adv(1); chk("nop_s4", 32'(step), 32'd1);

    // ADD with carry, then JC taken
    opcode = 4'd2; zf = 1'b0; cf = 1'b1;
    adv(4);
    chk("add_t4", 32'({alu_oe, a_load, alu_sub}), 32'b110);
    adv(1);
    opcode = 4'd7; adv(2);
    chk("jc_taken", 32'({ir_oe, pc_load}), 32'b11);
    adv(1);

    // SUB zero result: JZ taken, JC not taken
    opcode = 4'd3; zf = 1'b1; cf = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (alu_sub) cnt++;
      adv(1);
    end
    chk("sub_cycles", 32'(cnt), 32'd1);
    opcode = 4'd8; adv(2);
    chk("jz_taken", 32'(pc_load), 32'd1);
    adv(1);
    opcode = 4'd7; adv(2);
    chk("jc_not_taken", 32'({ir_oe, pc_load}), 32'b10);
    adv(1);

    // Remaining instruction shapes, checked by the model
    do_instr(4'd4, 1'b0, 1'b0);
    do_instr(4'd5, 1'b0, 1'b0);
    do_instr(4'd6, 1'b0, 1'b0);
    do_instr(4'd14, 1'b0, 1'b0);
    do_instr(4'd9, 1'b0, 1'b0);
    do_instr(4'd13, 1'b0, 1'b0);

    // LDA with run dropped during T3
    opcode = 4'd1; adv(3);
    run = 1'b0;
    chk("lda_t3", 32'({ram_oe, a_load}), 32'b11);
    adv(1);
    chk("lda_idle_step", 32'(step), 32'd0);
    chk("lda_idle_strobes", 32'(dut_strobes()), 32'd0);
    adv(1);
    chk("idle_hold", 32'(step), 32'd0);
    run = 1'b1; adv(1);
    chk("rerun_t0", 32'(step), 32'd1);

    // Random opcode stream (HLT excluded)
    for (int i = 0; i < 40; i++)
      do_instr(4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Set both flags, halt, then reset clears them
    do_instr(4'd2, 1'b1, 1'b1);
    opcode = 4'd15; adv(3);
    chk("halt_step", 32'(step), 32'd7);
    chk("halt_flag", 32'(halted), 32'd1);
    run = 1'b0; adv(2); run = 1'b1; adv(2);
    chk("halt_sticky", 32'({halted, step}), 32'b1111);
    rst = 1'b0; #1;
    chk("halt_rst_step", 32'(step), 32'd0);
    chk("halt_rst_halted", 32'(halted), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    opcode = 4'd8; adv(2);
    chk("flags_clr_jz", 32'(pc_load), 32'd0);
    adv(1);
    opcode = 4'd7; adv(2);
    chk("flags_clr_jc", 32'(pc_load), 32'd0);
    adv(1);

    // Async reset in the middle of ADD T4
    do_instr(4'd2, 1'b1, 1'b1);
    opcode = 4'd2; zf = 1'b1; cf = 1'b1;
    adv(4);
    chk("add2_t4", 32'(alu_oe), 32'd1);
    #2 rst = 1'b0; #1;
    chk("midrst_strobes", 32'(dut_strobes()), 32'd0);
    chk("midrst_step", 32'(step), 32'd0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    opcode = 4'd8; adv(2);
    chk("midrst_jz", 32'(pc_load), 32'd0);
    adv(1);
    opcode = 4'd7; adv(2);
    chk("midrst_jc", 32'(pc_load), 32'd0);
    adv(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/asap_control.md
# asap_control

Microcoded control sequencer for the ASAP-1 datapath. It steps a fetch/execute state machine and decodes the 4-bit opcode from the instruction register into per-cycle control strobes for the PC, MAR, RAM, IR, A/B registers, ALU (`alu_oe`, `alu_sub`) and output register. It also holds the registered zero and carry flags that gate conditional jumps. It sits beside the ALU and drives the `oe`/`sub` pins the ALU exposes.

## Interface
No parameters.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `run` in 1: 1 = execute; sampled only at instruction boundaries.
- `opcode` in 4: upper nibble of the IR, valid from T2 on.
- `zf` in 1: ALU zero output, combinational.
- `cf` in 1: ALU carry/borrow output, combinational.
- `pc_oe`, `pc_inc`, `pc_load` out 1: PC drive bus / increment / load from bus.
- `mar_load` out 1: MAR load from bus.
- `ram_oe`, `ram_load` out 1: RAM drive bus / write from bus.
- `ir_load`, `ir_oe` out 1: IR load from bus / drive operand nibble onto bus.
- `a_load`, `a_oe`, `b_load` out 1: A load / A drive / B load.
- `alu_oe`, `alu_sub` out 1: connected to the ALU `oe` and `sub` inputs.
- `out_load` out 1: output register load.
- `halted` out 1: high in HALT.
- `step` out 3: current state encoding, for debug.

## Operation
- States: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, HALT=7. Encoding 6 is illegal and returns to IDLE on the next clock.
- IDLE: no strobes. Go to T0 when `run`=1.
- T0: `pc_oe`, `mar_load`.
- T1: `ram_oe`, `ir_load`, `pc_inc`.
- Decode from T2 by opcode. The last listed step of each instruction goes to T0 if `run`=1, otherwise to IDLE.
  - 0 NOP: T2 empty.
  - 1 LDA: T2 `ir_oe`+`mar_load`; T3 `ram_oe`+`a_load`.
  - 2 ADD: T2 `ir_oe`+`mar_load`; T3 `ram_oe`+`b_load`; T4 `alu_oe`+`a_load`, flags latch.
  - 3 SUB: as ADD, with `alu_sub`=1 during T4 only.
  - 4 STA: T2 `ir_oe`+`mar_load`; T3 `a_oe`+`ram_load`.
  - 5 LDI: T2 `ir_oe`+`a_load`.
  - 6 JMP: T2 `ir_oe`+`pc_load`.
  - 7 JC: T2 `ir_oe`; `pc_load` only if `cflag`=1.
  - 8 JZ: T2 `ir_oe`; `pc_load` only if `zflag`=1.
  - 14 OUT: T2 `a_oe`+`out_load`.
  - 15 HLT: T2 no strobes, then go to HALT.
  - 9–13: treated as NOP.
- HALT: no strobes, `halted`=1. Only reset leaves HALT; `run` is ignored.
- Flags: `zflag`/`cflag` are internal registers that load `zf`/`cf` on the rising edge ending an ADD/SUB T4, and hold otherwise.
- Bus exclusivity: at most one of `pc_oe`, `ram_oe`, `ir_oe`, `a_oe`, `alu_oe` is high in any state. An assertion in the bench checks this.

## Timing
- Reset (`rst`=0, asynchronous):
  - state goes to IDLE, `zflag`=`cflag`=0;
  - every strobe and `halted` is 0, `step`=0.
- Release: with `run`=1, T0 strobes appear in the first cycle after the first rising edge.
- All strobes are combinational decodes of the registered state, opcode and flags. They are stable for the whole cycle and take effect at the next rising edge.
- Instruction length in cycles, excluding IDLE:
  - NOP/JMP/JC/JZ/LDI/OUT/HLT: 3;
  - LDA/STA: 4;
  - ADD/SUB: 5.
- `run` dropped mid-instruction: the instruction completes, then the sequencer enters IDLE.
- `run` re-asserted in IDLE: T0 follows on the next edge.
- Reset mid-instruction: the state is abandoned immediately and the flags clear. There is no partial write-back beyond edges already taken.
- The flag latch and `a_load` in T4 happen on the same edge, so a following JZ/JC sees the new flags.
- A JC/JZ that is not taken still spends T2 and only `ir_oe` pulses.

## Test plan
- Reset then `run`=1, opcode=0 → `step` sequence 1,2,3,1; only T0/T1 strobes ever high.
- ADD (opcode 2), ALU returns `zf`=0/`cf`=1 → T4 has `alu_oe`=`a_load`=1 and `alu_sub`=0. A following JC (7) asserts `pc_load` in its T2.
- SUB (opcode 3) with `zf`=1, `cf`=0, then JZ (8) then JC (7) → JZ takes `pc_load`=1; JC has `pc_load`=0; `alu_sub`=1 exactly one cycle.
- HLT (15) → `halted`=1 from the cycle after T2, `step`=7. `run` toggling has no effect; `rst` pulse returns to `step`=0 with flags 0.
- `run` deasserted during T3 of LDA (1) → T3 completes, then `step`=0 and strobes are 0. Reassert → T0 on the next edge.
- Async `rst` pulse mid-cycle during ADD T4 → outputs drop to 0 before the next edge and `zflag`/`cflag` read 0. Random-opcode run: the bus-exclusivity assertion never fires.
